// File: rtl/decode_channel_queue_pkg.sv
// Shared decode-stage definitions: arbitration modes, channel indices and
// the packed decoded-instruction layout carried through the channel queue.
package decode_channel_queue_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_D = 2;

    typedef struct packed {
        logic [15:0]  opcode;
        logic [63:0]  address;
        logic [7:0]   thread_id;
        logic [7:0]   inst_id;
        logic [15:0]  operand_flags;
        logic [143:0] body;
    } decoded_instr_t;

    localparam int DECODED_INSTR_W = $bits(decoded_instr_t);

    function automatic int next_index(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/decode_channel_queue_arbiter.sv
// Channel arbiter for the decode queue: fixed-priority or round-robin grant,
// one-hot plus encoded index, owning the last-grant pointer.
module decode_rr_arbiter
    import decode_channel_queue_pkg::*;
#(
    parameter int NumChannels = 3,
    parameter int ArbMode     = ARB_RR
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic [NumChannels-1:0]         req_i,
    input  logic                           en_i,
    output logic [NumChannels-1:0]         grant_o,
    output logic [$clog2(NumChannels)-1:0] index_o
);

    localparam int IdxW = $clog2(NumChannels);

    logic [IdxW-1:0] last_grant_q;
    logic [IdxW-1:0] last_grant_d;
    logic            found;
    int              cand;

    always_comb begin
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        cand    = 0;
        if (en_i) begin
            if (ArbMode == ARB_FIXED) begin
                for (int c = 0; c < NumChannels; c++) begin
                    if (!found && req_i[c]) begin
                        found   = 1'b1;
                        index_o = IdxW'(c);
                    end
                end
            end else begin
                // Search begins one past the previous winner and wraps.
                cand = int'(last_grant_q);
                for (int k = 0; k < NumChannels; k++) begin
                    cand = next_index(cand, NumChannels);
                    if (!found && req_i[cand]) begin
                        found   = 1'b1;
                        index_o = IdxW'(cand);
                    end
                end
            end
        end
        if (found) begin
            grant_o[index_o] = 1'b1;
        end
        last_grant_d = found ? index_o : last_grant_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= IdxW'(NumChannels - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/decode_channel_queue.sv
// Decode-stage channel queue: arbitrates decoder channels into a
// first-word-fall-through buffer that feeds rename/dispatch.
module decode_channel_queue
    import decode_channel_queue_pkg::*;
#(
    parameter int NumChannels  = 3,
    parameter int PayloadWidth = DECODED_INSTR_W,
    parameter int Depth        = 4,
    parameter int ArbMode      = ARB_RR
) (
    input  logic                                clock_i,
    input  logic                                reset_n_i,
    input  logic                                flush_i,
    input  logic [NumChannels-1:0]              chanValid_i,
    input  logic [NumChannels*PayloadWidth-1:0] chanPayload_i,
    output logic [NumChannels-1:0]              chanReady_o,
    output logic                                valid_o,
    output logic [PayloadWidth-1:0]             payload_o,
    output logic [$clog2(NumChannels)-1:0]      source_o,
    input  logic                                ready_i,
    output logic [$clog2(Depth):0]              count_o,
    output logic                                full_o,
    output logic                                empty_o
);

    localparam int SrcW = $clog2(NumChannels);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic            arb_en;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [SrcW-1:0] grant_idx;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [PayloadWidth-1:0] mem_payload_q [Depth];
    logic [SrcW-1:0]         mem_source_q  [Depth];

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // Readiness uses only registered occupancy, so a full queue refuses a
    // push even when the head is consumed in the same cycle.
    assign arb_en = !full && !flush_i;

    decode_rr_arbiter #(
        .NumChannels (NumChannels),
        .ArbMode     (ArbMode)
    ) u_arbiter (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .req_i     (chanValid_i),
        .en_i      (arb_en),
        .grant_o   (chanReady_o),
        .index_o   (grant_idx)
    );

    assign push = |chanReady_o;
    assign pop  = !empty && ready_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy alone qualifies the head.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_payload_q[wr_ptr_q] <= chanPayload_i[grant_idx*PayloadWidth +: PayloadWidth];
            mem_source_q[wr_ptr_q]  <= grant_idx;
        end
    end

    assign valid_o   = !empty;
    assign payload_o = mem_payload_q[rd_ptr_q];
    assign source_o  = mem_source_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full;
    assign empty_o   = empty;

endmodule

// File: tb/tb_decode_channel_queue.sv
// Directed bench for decode_channel_queue: vector table plus hand-written
// sequences for flush and asynchronous reset.
module tb_decode_channel_queue;
    import decode_channel_queue_pkg::*;

    localparam int NC = 3;
    localparam int PW = 256;
    localparam int D  = 4;
    localparam int NV = 21;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             ready = 1'b0;
    logic [NC-1:0]    valid = '0;
    logic [NC*PW-1:0] chan_payload;
    logic [PW-1:0]    chan_pay [NC];

    logic [NC-1:0] grant_rr, grant_fx;
    logic          vo_rr, vo_fx, full_rr, full_fx, empty_rr, empty_fx;
    logic [PW-1:0] pay_rr, pay_fx;
    logic [1:0]    src_rr, src_fx;
    logic [2:0]    cnt_rr, cnt_fx;

    int n_cmp = 0;
    int n_err = 0;
    int chan_seq [NC];

    typedef struct {
        logic [NC-1:0] valid;
        logic          ready;
        logic [NC-1:0] grant_rr;
        logic [NC-1:0] grant_fx;
        int            count;
    } vec_t;
    vec_t vecs [NV];

    typedef struct {
        int            src;
        logic [PW-1:0] pay;
    } ent_t;
    ent_t sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_pay
        assign chan_payload[g*PW +: PW] = chan_pay[g];
    end

    decode_channel_queue #(.NumChannels(NC), .PayloadWidth(PW), .Depth(D), .ArbMode(ARB_RR)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush), .chanValid_i(valid),
        .chanPayload_i(chan_payload), .chanReady_o(grant_rr), .valid_o(vo_rr),
        .payload_o(pay_rr), .source_o(src_rr), .ready_i(ready), .count_o(cnt_rr),
        .full_o(full_rr), .empty_o(empty_rr)
    );

    decode_channel_queue #(.NumChannels(NC), .PayloadWidth(PW), .Depth(D), .ArbMode(ARB_FIXED)) dut_fx (
        .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush), .chanValid_i(valid),
        .chanPayload_i(chan_payload), .chanReady_o(grant_fx), .valid_o(vo_fx),
        .payload_o(pay_fx), .source_o(src_fx), .ready_i(ready), .count_o(cnt_fx),
        .full_o(full_fx), .empty_o(empty_fx)
    );

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_pay(input int c);
        chan_pay[c] = PW'(32'hD0000 | (c << 12) | chan_seq[c]);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid, ready, rr grant, fixed grant, count seen this cycle
        vecs[0]  = '{3'b111, 1'b1, 3'b001, 3'b001, 0};
        vecs[1]  = '{3'b111, 1'b1, 3'b010, 3'b001, 1};
        vecs[2]  = '{3'b111, 1'b1, 3'b100, 3'b001, 1};
        vecs[3]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1};
        vecs[4]  = '{3'b111, 1'b1, 3'b010, 3'b001, 1};
        vecs[5]  = '{3'b111, 1'b1, 3'b100, 3'b001, 1};
        vecs[6]  = '{3'b000, 1'b1, 3'b000, 3'b000, 1};
        vecs[7]  = '{3'b000, 1'b0, 3'b000, 3'b000, 0};
        vecs[8]  = '{3'b011, 1'b0, 3'b001, 3'b001, 0};
        vecs[9]  = '{3'b011, 1'b0, 3'b010, 3'b001, 1};
        vecs[10] = '{3'b011, 1'b0, 3'b001, 3'b001, 2};
        vecs[11] = '{3'b011, 1'b0, 3'b010, 3'b001, 3};
        vecs[12] = '{3'b011, 1'b0, 3'b000, 3'b000, 4};
        vecs[13] = '{3'b011, 1'b0, 3'b000, 3'b000, 4};
        vecs[14] = '{3'b011, 1'b1, 3'b000, 3'b000, 4};
        vecs[15] = '{3'b011, 1'b1, 3'b001, 3'b001, 3};
        vecs[16] = '{3'b000, 1'b1, 3'b000, 3'b000, 3};
        vecs[17] = '{3'b100, 1'b1, 3'b100, 3'b100, 2};
        vecs[18] = '{3'b000, 1'b1, 3'b000, 3'b000, 2};
        vecs[19] = '{3'b000, 1'b1, 3'b000, 3'b000, 1};
        vecs[20] = '{3'b000, 1'b0, 3'b000, 3'b000, 0};

        for (int c = 0; c < NC; c++) begin
            chan_seq[c] = 0;
            refresh_pay(c);
        end

        #12;
        check("reset valid_o", PW'(vo_rr), PW'(0));
        check("reset empty_o", PW'(empty_rr), PW'(1));
        check("reset full_o", PW'(full_rr), PW'(0));
        check("reset count_o", PW'(cnt_rr), PW'(0));
        check("reset chanReady_o", PW'(grant_rr), PW'(0));
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            int gidx;
            valid = vecs[i].valid;
            ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("v%0d grant_rr", i), PW'(grant_rr), PW'(vecs[i].grant_rr));
            check($sformatf("v%0d grant_fx", i), PW'(grant_fx), PW'(vecs[i].grant_fx));
            check($sformatf("v%0d count", i), PW'(cnt_rr), PW'(vecs[i].count));
            check($sformatf("v%0d valid_o", i), PW'(vo_rr), PW'(vecs[i].count != 0));
            check($sformatf("v%0d full_o", i), PW'(full_rr), PW'(vecs[i].count == D));
            check($sformatf("v%0d empty_o", i), PW'(empty_rr), PW'(vecs[i].count == 0));
            if (vecs[i].count != 0 && sb.size() > 0) begin
                check($sformatf("v%0d source_o", i), PW'(src_rr), PW'(sb[0].src));
                check($sformatf("v%0d payload_o", i), pay_rr, sb[0].pay);
                if (vecs[i].ready) void'(sb.pop_front());
            end
            gidx = -1;
            for (int c = 0; c < NC; c++) if (vecs[i].grant_rr[c]) gidx = c;
            if (gidx >= 0) sb.push_back('{gidx, chan_pay[gidx]});
            next_cycle();
            if (gidx >= 0) begin
                chan_seq[gidx]++;
                refresh_pay(gidx);
            end
        end

        // Single beat from channel B into an empty queue.
        valid = 3'b010;
        chan_pay[1] = PW'(8'hB1);
        @(negedge clk);
        check("single grant", PW'(grant_rr), PW'(3'b010));
        next_cycle();
        valid = 3'b000;
        ready = 1'b1;
        @(negedge clk);
        check("single valid_o", PW'(vo_rr), PW'(1));
        check("single payload_o", pay_rr, PW'(8'hB1));
        check("single source_o", PW'(src_rr), PW'(1));
        next_cycle();
        ready = 1'b0;

        // Flush with three entries while channel D waits.
        valid = 3'b001;
        repeat (3) next_cycle();
        valid = 3'b100;
        flush = 1'b1;
        @(negedge clk);
        check("flush count before", PW'(cnt_rr), PW'(3));
        check("flush grant_rr", PW'(grant_rr), PW'(0));
        check("flush grant_fx", PW'(grant_fx), PW'(0));
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("post-flush count", PW'(cnt_rr), PW'(0));
        check("post-flush valid_o", PW'(vo_rr), PW'(0));
        check("post-flush fx count", PW'(cnt_fx), PW'(0));
        check("post-flush grant", PW'(grant_rr), PW'(3'b100));
        next_cycle();
        valid = 3'b000;
        @(negedge clk);
        check("post-flush head valid", PW'(vo_rr), PW'(1));
        check("post-flush head source", PW'(src_rr), PW'(2));
        check("post-flush head payload", pay_rr, chan_pay[2]);
        ready = 1'b1;
        next_cycle();
        ready = 1'b0;

        // Asynchronous reset with two entries; round-robin restarts at A.
        valid = 3'b010;
        repeat (2) next_cycle();
        valid = 3'b000;
        @(negedge clk);
        check("pre-reset count", PW'(cnt_rr), PW'(2));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset valid_o", PW'(vo_rr), PW'(0));
        check("async reset count_o", PW'(cnt_rr), PW'(0));
        check("async reset empty_o", PW'(empty_rr), PW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        valid = 3'b111;
        #1;
        check("rr restart grant", PW'(grant_rr), PW'(3'b001));
        next_cycle();
        valid = 3'b000;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
